// File: rtl/pixel_window_generator.sv
// Raster RGB stream to KERNEL x KERNEL neighbourhood windows using KERNEL-1 line buffers.
// Optional macro PIXEL_WINDOW_POS_EN adds registered window-centre coordinate outputs.
module pixel_window_generator #(
  parameter int KERNEL        = 3,
  parameter int COLOR_CHANNEL = 8,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic                                          i_pixel_valid,
  input  logic                                          i_pixel_sof,
  input  logic [2:0][COLOR_CHANNEL-1:0]                 i_pixel_data,
  output logic                                          o_window_valid,
  output logic [KERNEL-1:0][2:0][COLOR_CHANNEL-1:0]     o_pixel_area_data [KERNEL-1:0]
`ifdef PIXEL_WINDOW_POS_EN
  ,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]               o_window_row,
  output logic [$clog2(IMAGE_WIDTH)-1:0]                o_window_col
`endif
);

  localparam int COL_W = $clog2(IMAGE_WIDTH);
  localparam int ROW_W = $clog2(IMAGE_HEIGHT);
  localparam int HALF  = (KERNEL - 1) / 2;
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL - 1);

  typedef logic [2:0][COLOR_CHANNEL-1:0] pixel_t;

  pixel_t                lb_mem [KERNEL-1][IMAGE_WIDTH];
  pixel_t                lb_rd  [KERNEL-1];
  pixel_t                new_col [KERNEL];
  logic [COL_W-1:0]      col_cnt, col_eff;
  logic [ROW_W-1:0]      row_cnt, row_eff;
  logic                  sof_acc;
  logic                  win_done;

  logic                                       vld_p0;
  logic [KERNEL-1:0][2:0][COLOR_CHANNEL-1:0]  win_p0 [KERNEL-1:0];

  // Accept stage: sof overrides the counters, buffers read before they are overwritten
  always_comb begin
    sof_acc  = i_pixel_valid && i_pixel_sof;
    col_eff  = sof_acc ? '0 : col_cnt;
    row_eff  = sof_acc ? '0 : row_cnt;
    win_done = (row_eff >= ROW_FIRST) && (col_eff >= COL_FIRST);
    for (int m = 0; m < KERNEL - 1; m++) begin
      lb_rd[m] = lb_mem[m][col_eff];
    end
    new_col[KERNEL-1] = i_pixel_data;
    for (int j = 0; j < KERNEL - 1; j++) begin
      new_col[j] = lb_rd[KERNEL-2-j];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_pixel_valid) begin
      lb_mem[0][col_eff] <= i_pixel_data;
      for (int m = 1; m < KERNEL - 1; m++) begin
        lb_mem[m][col_eff] <= lb_rd[m-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= i_pixel_valid && win_done;
      if (i_pixel_valid) begin
        if (col_eff == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
        end else begin
          col_cnt <= col_eff + 1'b1;
          row_cnt <= row_eff;
        end
      end
    end
  end

  // Output stage: window column shift, newest column enters at k = KERNEL-1
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int j = 0; j < KERNEL; j++) win_p0[j] <= '0;
    end else if (i_pixel_valid) begin
      for (int j = 0; j < KERNEL; j++) begin
        win_p0[j] <= {new_col[j], win_p0[j][KERNEL-1:1]};
      end
    end
  end

  assign o_window_valid    = vld_p0;
  assign o_pixel_area_data = win_p0;

`ifdef PIXEL_WINDOW_POS_EN
  logic [ROW_W-1:0] row_p0;
  logic [COL_W-1:0] col_p0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row_p0 <= '0;
      col_p0 <= '0;
    end else if (i_pixel_valid) begin
      row_p0 <= row_eff - ROW_W'(HALF);
      col_p0 <= col_eff - COL_W'(HALF);
    end
  end

  assign o_window_row = row_p0;
  assign o_window_col = col_p0;
`endif

endmodule

// File: tb/tb_pixel_window_generator.sv
// Directed bench for pixel_window_generator: 3x3 kernel on an 8x6 frame, pixel (r,c) = r*16+c.
module tb_pixel_window_generator;

  localparam int K  = 3;
  localparam int CC = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  logic                          i_clk = 1'b0;
  logic                          i_rst;
  logic                          i_pixel_valid;
  logic                          i_pixel_sof;
  logic [2:0][CC-1:0]            i_pixel_data;
  logic                          o_window_valid;
  logic [K-1:0][2:0][CC-1:0]     o_pixel_area_data [K-1:0];
`ifdef PIXEL_WINDOW_POS_EN
  logic [$clog2(H)-1:0]          o_window_row;
  logic [$clog2(W)-1:0]          o_window_col;
`endif

  int n_vec = 0;
  int n_err = 0;
  int win_cnt, pix_cnt, first_idx;

  pixel_window_generator #(
    .KERNEL(K), .COLOR_CHANNEL(CC), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_pixel_valid(i_pixel_valid),
    .i_pixel_sof(i_pixel_sof),
    .i_pixel_data(i_pixel_data),
    .o_window_valid(o_window_valid),
    .o_pixel_area_data(o_pixel_area_data)
`ifdef PIXEL_WINDOW_POS_EN
    ,
    .o_window_row(o_window_row),
    .o_window_col(o_window_col)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_row(input int r, input int c, input int j);
    logic [K-1:0][2:0][CC-1:0] v;
    for (int k = 0; k < K; k++)
      for (int ch = 0; ch < 3; ch++)
        v[k][ch] = CC'((r - (K-1) + j) * 16 + (c - (K-1) + k));
    return 128'(v);
  endfunction

  task automatic send_pix(input int r, input int c, input bit sof);
    bit exp_v;
    i_pixel_valid = 1'b1;
    i_pixel_sof   = sof;
    i_pixel_data  = {3{CC'(r * 16 + c)}};
    @(posedge i_clk); #1;
    i_pixel_valid = 1'b0;
    i_pixel_sof   = 1'b0;
    pix_cnt++;
    exp_v = (r >= K-1) && (c >= K-1);
    chk("win_vld", 128'(o_window_valid), 128'(exp_v));
    if (exp_v) begin
      win_cnt++;
      if (win_cnt == 1) begin
        first_idx = pix_cnt;
        chk("first_00", 128'(o_pixel_area_data[0][0]), 128'({3{8'h00}}));
        chk("first_11", 128'(o_pixel_area_data[1][1]), 128'({3{8'h11}}));
        chk("first_22", 128'(o_pixel_area_data[2][2]), 128'({3{8'h22}}));
      end
      for (int j = 0; j < K; j++)
        chk($sformatf("row%0d@%0d,%0d", j, r, c), 128'(o_pixel_area_data[j]), exp_row(r, c, j));
`ifdef PIXEL_WINDOW_POS_EN
      chk("pos_row", 128'(o_window_row), 128'(r - 1));
      chk("pos_col", 128'(o_window_col), 128'(c - 1));
`endif
    end
  endtask

  task automatic idle_cycle();
    i_pixel_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("gap_vld", 128'(o_window_valid), 128'(0));
  endtask

  task automatic send_frame(input bit use_sof, input bit gaps, input int stop_r, input int stop_c);
    win_cnt = 0; pix_cnt = 0; first_idx = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        if (gaps && $urandom_range(0, 2) == 0)
          repeat ($urandom_range(1, 2)) idle_cycle();
        send_pix(r, c, use_sof && r == 0 && c == 0);
      end
  endtask

  task automatic frame_checks(input string tag);
    chk({tag, "_nwin"}, 128'(win_cnt), 128'(24));
    chk({tag, "_first"}, 128'(first_idx), 128'(19));
    chk({tag, "_last22"}, 128'(o_pixel_area_data[2][2]), 128'({3{8'h57}}));
`ifdef PIXEL_WINDOW_POS_EN
    chk({tag, "_lastrow"}, 128'(o_window_row), 128'(4));
    chk({tag, "_lastcol"}, 128'(o_window_col), 128'(6));
`endif
  endtask

  initial begin
    i_rst = 1'b1; i_pixel_valid = 1'b0; i_pixel_sof = 1'b0; i_pixel_data = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_vld", 128'(o_window_valid), 128'(0));
    for (int j = 0; j < K; j++) chk("rst_data", 128'(o_pixel_area_data[j]), 128'(0));
`ifdef PIXEL_WINDOW_POS_EN
    chk("rst_row", 128'(o_window_row), 128'(0));
    chk("rst_col", 128'(o_window_col), 128'(0));
`endif
    i_rst = 1'b0;

    send_frame(1'b1, 1'b0, -1, -1);
    frame_checks("cont");
    idle_cycle();

    send_frame(1'b1, 1'b1, -1, -1);
    frame_checks("gaps");

    send_frame(1'b1, 1'b0, -1, -1);
    send_frame(1'b1, 1'b0, -1, -1);
    frame_checks("b2b");

    send_frame(1'b1, 1'b0, 3, 4);
    send_frame(1'b1, 1'b0, -1, -1);
    frame_checks("resync");

    send_frame(1'b1, 1'b0, 3, 3);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("midrst_vld", 128'(o_window_valid), 128'(0));
    for (int j = 0; j < K; j++) chk("midrst_data", 128'(o_pixel_area_data[j]), 128'(0));
    send_frame(1'b0, 1'b0, -1, -1);
    frame_checks("afterrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_window_generator.md
# pixel_window_generator

Turns a raster-order RGB pixel stream into KERNEL×KERNEL neighbourhood windows, one window per accepted pixel whose window lies fully inside the frame. It sits directly upstream of the per-channel convolution set and drives its pixel-area input in that block's layout. It uses KERNEL−1 line buffers plus a KERNEL×KERNEL shift-register window. Only "valid" windows are produced: the output image is (IMAGE_WIDTH−KERNEL+1)×(IMAGE_HEIGHT−KERNEL+1).

## Interface
- KERNEL, 3: window side length (odd, ≥3).
- COLOR_CHANNEL, 8: bits per colour channel.
- IMAGE_WIDTH, 640: pixels per line (≥KERNEL).
- IMAGE_HEIGHT, 480: lines per frame (≥KERNEL).
- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_pixel_valid  in  1  pixel accepted on this edge when high; no backpressure.
- i_pixel_sof  in  1  qualified by i_pixel_valid; marks pixel (row 0, col 0).
- i_pixel_data  in  [2:0][COLOR_CHANNEL-1:0]  channel 0..2.
- o_window_valid  out  1  o_pixel_area_data holds a complete window.
- o_pixel_area_data  out  [KERNEL-1:0][2:0][COLOR_CHANNEL-1:0] × [KERNEL-1:0] (unpacked outer)  element [j][k][c] = row j (0 = oldest/top), column k (0 = leftmost), channel c.
- o_window_row, o_window_col  out  $clog2(IMAGE_HEIGHT), $clog2(IMAGE_WIDTH)  only with PIXEL_WINDOW_POS_EN; centre coordinates of current window.

## Operation
- Row/col counters track the incoming pixel. col wraps IMAGE_WIDTH−1→0 with row+1. After (IMAGE_HEIGHT−1, IMAGE_WIDTH−1), both return to 0.
- i_pixel_valid & i_pixel_sof: the pixel is treated as (0,0) regardless of counters. Line-buffer contents are kept but not used until overwritten, because validity depends on the counters only.
- Per accepted pixel at (r,c):
  - line buffer m (m=0..KERNEL−2) yields pixel (r−1−m, c);
  - the column {buffer KERNEL−2 … buffer 0, input} is shifted into window column KERNEL−1, and older columns shift toward k=0;
  - the input is written into buffer 0, and buffer m's old value is written into buffer m+1, all at address c.
- Window is complete when r ≥ KERNEL−1 and c ≥ KERNEL−1. Columns never straddle lines under this rule.
- No accept cycle: window, counters, buffers hold; o_window_valid drops to 0.
- Reset: counters 0, o_window_valid 0, o_pixel_area_data all-zero, position outputs 0. Buffer RAM contents are not cleared. Reset mid-frame discards the frame, and the next accepted pixel is (0,0).
- No arithmetic beyond counters; counter widths are $clog2 of the dimension and never exceed the dimension minus one.

## Timing
- Latency 1: pixel accepted at edge N → o_window_valid/o_pixel_area_data updated at edge N, visible in cycle N+1. This includes the line-buffer read, so a read-before-write RAM at address c is required.
- o_window_valid is high exactly one cycle per accepted completing pixel; back-to-back valid input gives back-to-back windows.
- Outputs are registered; no combinational input→output path.

## Configuration
- PIXEL_WINDOW_POS_EN defined: o_window_row = r−(KERNEL−1)/2 and o_window_col = c−(KERNEL−1)/2, registered alongside the window.
- PIXEL_WINDOW_POS_EN undefined: the position ports and their registers do not exist; all other behaviour is identical.

## Test plan
Common setup: KERNEL=3, IMAGE_WIDTH=8, IMAGE_HEIGHT=6, COLOR_CHANNEL=8, every channel of pixel (r,c) = r*16+c.
- Continuous valid frame with sof on first pixel:
  - the first o_window_valid follows the 19th pixel (2,2) with [0][0]=0x00, [1][1]=0x11, [2][2]=0x22 on all channels;
  - 24 windows per frame;
  - the last window has [2][2]=0x57.
- Same frame with random valid gaps: identical window sequence and values, and o_window_valid is never high on a gap-following idle cycle.
- Two frames back-to-back: the second frame's first window again appears at its pixel (2,2) with [0][0]=0x00, with no window emitted during its rows 0–1.
- sof asserted at old pixel (3,4): counters resync, and the next window appears 18 pixels later with values from the new frame only.
- i_rst for 1 cycle mid-row 3: o_window_valid=0 and o_pixel_area_data=0 next cycle, then the full first-frame sequence repeats from the next accepted pixel.
- With PIXEL_WINDOW_POS_EN: the first window reports row=1, col=1 and the last reports row=4, col=6; a build without the macro compiles with the ports absent.
